// File: rtl/controlador_cabine.sv
// Elevator car controller: follows the selector's target floor one floor at a time,
// times travel and door dwell, and pulses the call-clear line for each floor served.
module controlador_cabine #(
  parameter int TEMPO_ANDAR = 8,
  parameter int TEMPO_PORTA = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] andar_alvo,
  output logic [1:0] andar_atual,
  output logic       subindo,
  output logic       movendo,
  output logic       porta_aberta,
  output logic [2:0] limpa_chamada
);

  typedef enum logic [1:0] {PARADO, MOVENDO, PORTA_ABERTA} estado_t;

  localparam logic [7:0] TA_M1 = 8'(TEMPO_ANDAR - 1);
  localparam logic [7:0] TP_M1 = 8'(TEMPO_PORTA - 1);

  estado_t    estado_q, estado_d;
  logic [7:0] cont_q, cont_d;
  logic [1:0] andar_q, andar_d;
  logic       subindo_q, subindo_d;
  logic       movendo_q, movendo_d;
  logic       porta_q, porta_d;
  logic [2:0] limpa_q, limpa_d;
  logic [1:0] prox_andar;
  logic       no_limite;

  function automatic logic [2:0] um_quente(input logic [1:0] f);
    case (f)
      2'd1:    um_quente = 3'b001;
      2'd2:    um_quente = 3'b010;
      2'd3:    um_quente = 3'b100;
      default: um_quente = 3'b000;
    endcase
  endfunction

  always_comb begin
    estado_d   = estado_q;
    cont_d     = cont_q;
    andar_d    = andar_q;
    subindo_d  = subindo_q;
    movendo_d  = movendo_q;
    porta_d    = porta_q;
    limpa_d    = 3'b000;
    prox_andar = subindo_q ? andar_q + 2'd1 : andar_q - 2'd1;
    // Stepping out of 1..3 should never be requested; treat it as an end stop.
    no_limite  = (subindo_q && andar_q == 2'd3) || (!subindo_q && andar_q == 2'd1);

    case (estado_q)
      PARADO: begin
        if (andar_alvo != 2'd0) begin
          if (andar_alvo == andar_q) begin
            estado_d = PORTA_ABERTA;
            porta_d  = 1'b1;
            limpa_d  = um_quente(andar_q);
            cont_d   = TP_M1;
          end else begin
            estado_d  = MOVENDO;
            subindo_d = (andar_alvo > andar_q);
            movendo_d = 1'b1;
            cont_d    = TA_M1;
          end
        end
      end

      MOVENDO: begin
        if (cont_q != 8'd0) begin
          cont_d = cont_q - 8'd1;
        end else if (no_limite) begin
          estado_d  = PARADO;
          movendo_d = 1'b0;
        end else begin
          andar_d = prox_andar;
          // Target is re-evaluated live against the floor just reached.
          if (andar_alvo == prox_andar) begin
            estado_d  = PORTA_ABERTA;
            movendo_d = 1'b0;
            porta_d   = 1'b1;
            limpa_d   = um_quente(prox_andar);
            cont_d    = TP_M1;
          end else if (andar_alvo == 2'd0 ||
                       (subindo_q ? (andar_alvo < prox_andar) : (andar_alvo > prox_andar))) begin
            estado_d  = PARADO;
            movendo_d = 1'b0;
            cont_d    = 8'd0;
          end else begin
            cont_d = TA_M1;
          end
        end
      end

      PORTA_ABERTA: begin
        if (cont_q == 8'd0) begin
          estado_d = PARADO;
          porta_d  = 1'b0;
        end else if (andar_alvo == andar_q) begin
          cont_d  = TP_M1;
          limpa_d = um_quente(andar_q);
        end else begin
          cont_d = cont_q - 8'd1;
        end
      end

      default: estado_d = PARADO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= PARADO;
      cont_q    <= 8'd0;
      andar_q   <= 2'd1;
      subindo_q <= 1'b0;
      movendo_q <= 1'b0;
      porta_q   <= 1'b0;
      limpa_q   <= 3'b000;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      andar_q   <= andar_d;
      subindo_q <= subindo_d;
      movendo_q <= movendo_d;
      porta_q   <= porta_d;
      limpa_q   <= limpa_d;
    end
  end

  assign andar_atual   = andar_q;
  assign subindo       = subindo_q;
  assign movendo       = movendo_q;
  assign porta_aberta  = porta_q;
  assign limpa_chamada = limpa_q;

endmodule

// File: tb/tb_controlador_cabine.sv
// Directed bench for controlador_cabine with TEMPO_ANDAR = 8, TEMPO_PORTA = 4.
// Status vector layout: {andar_atual[1:0], subindo, movendo, porta_aberta, limpa_chamada[2:0]}.
module tb_controlador_cabine;

  logic       clk;
  logic       rst;
  logic [1:0] andar_alvo;
  logic [1:0] andar_atual;
  logic       subindo, movendo, porta_aberta;
  logic [2:0] limpa_chamada;
  logic [7:0] st;
  logic       chk_on;
  int         errors;
  int         checks;

  controlador_cabine #(.TEMPO_ANDAR(8), .TEMPO_PORTA(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .andar_alvo    (andar_alvo),
    .andar_atual   (andar_atual),
    .subindo       (subindo),
    .movendo       (movendo),
    .porta_aberta  (porta_aberta),
    .limpa_chamada (limpa_chamada)
  );

  assign st = {andar_atual, subindo, movendo, porta_aberta, limpa_chamada};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (!(andar_atual === 2'd1 || andar_atual === 2'd2 || andar_atual === 2'd3)) begin
        errors++;
        $display("FAIL floor_range: andar_atual=%b not in {01,10,11}", andar_atual);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    andar_alvo = 2'd0;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    andar_alvo = 2'd3;
    tick(1);
    chk_on = 1'b1;
    checks++; if (st !== 8'b01_0_0_0_000) begin errors++; $display("FAIL reset_c1: got %b exp %b", st, 8'b01_0_0_0_000); end
    tick(1);
    checks++; if (st !== 8'b01_0_0_0_000) begin errors++; $display("FAIL reset_c2: got %b exp %b", st, 8'b01_0_0_0_000); end
    rst = 1'b0;
  endtask

  task automatic test_full_climb();
    andar_alvo = 2'd3;
    tick(1);
    checks++; if (st !== 8'b01_1_1_0_000) begin errors++; $display("FAIL climb_start: got %b exp %b", st, 8'b01_1_1_0_000); end
    tick(7);
    checks++; if (st !== 8'b01_1_1_0_000) begin errors++; $display("FAIL climb_pre_f2: got %b exp %b", st, 8'b01_1_1_0_000); end
    tick(1);
    checks++; if (st !== 8'b10_1_1_0_000) begin errors++; $display("FAIL climb_f2: got %b exp %b", st, 8'b10_1_1_0_000); end
    tick(7);
    checks++; if (st !== 8'b10_1_1_0_000) begin errors++; $display("FAIL climb_pre_f3: got %b exp %b", st, 8'b10_1_1_0_000); end
    tick(1);
    checks++; if (st !== 8'b11_1_0_1_100) begin errors++; $display("FAIL climb_f3_door: got %b exp %b", st, 8'b11_1_0_1_100); end
    andar_alvo = 2'd0;
    tick(1);
    checks++; if (st !== 8'b11_1_0_1_000) begin errors++; $display("FAIL climb_door_c2: got %b exp %b", st, 8'b11_1_0_1_000); end
    tick(2);
    checks++; if (st !== 8'b11_1_0_1_000) begin errors++; $display("FAIL climb_door_c4: got %b exp %b", st, 8'b11_1_0_1_000); end
    tick(1);
    checks++; if (st !== 8'b11_1_0_0_000) begin errors++; $display("FAIL climb_door_close: got %b exp %b", st, 8'b11_1_0_0_000); end
    tick(1);
    checks++; if (st !== 8'b11_1_0_0_000) begin errors++; $display("FAIL climb_idle: got %b exp %b", st, 8'b11_1_0_0_000); end
  endtask

  task automatic test_same_floor();
    apply_reset();
    andar_alvo = 2'd1;
    tick(1);
    checks++; if (st !== 8'b01_0_0_1_001) begin errors++; $display("FAIL same_open: got %b exp %b", st, 8'b01_0_0_1_001); end
    andar_alvo = 2'd0;
    tick(1);
    checks++; if (st !== 8'b01_0_0_1_000) begin errors++; $display("FAIL same_c2: got %b exp %b", st, 8'b01_0_0_1_000); end
    tick(2);
    checks++; if (st !== 8'b01_0_0_1_000) begin errors++; $display("FAIL same_c4: got %b exp %b", st, 8'b01_0_0_1_000); end
    tick(1);
    checks++; if (st !== 8'b01_0_0_0_000) begin errors++; $display("FAIL same_close: got %b exp %b", st, 8'b01_0_0_0_000); end
  endtask

  task automatic test_intermediate_stop();
    apply_reset();
    andar_alvo = 2'd3;
    tick(1);
    checks++; if (st !== 8'b01_1_1_0_000) begin errors++; $display("FAIL inter_start: got %b exp %b", st, 8'b01_1_1_0_000); end
    tick(3);
    andar_alvo = 2'd2;
    tick(5);
    checks++; if (st !== 8'b10_1_0_1_010) begin errors++; $display("FAIL inter_arrive: got %b exp %b", st, 8'b10_1_0_1_010); end
    andar_alvo = 2'd0;
    tick(1);
    checks++; if (st !== 8'b10_1_0_1_000) begin errors++; $display("FAIL inter_pulse_once: got %b exp %b", st, 8'b10_1_0_1_000); end
    tick(3);
    checks++; if (st !== 8'b10_1_0_0_000) begin errors++; $display("FAIL inter_close: got %b exp %b", st, 8'b10_1_0_0_000); end
    tick(3);
    checks++; if (st !== 8'b10_1_0_0_000) begin errors++; $display("FAIL inter_stays: got %b exp %b", st, 8'b10_1_0_0_000); end
  endtask

  task automatic test_reversal();
    apply_reset();
    andar_alvo = 2'd3;
    tick(1);
    tick(3);
    andar_alvo = 2'd1;
    tick(5);
    checks++; if (st !== 8'b10_1_0_0_000) begin errors++; $display("FAIL rev_stop_f2: got %b exp %b", st, 8'b10_1_0_0_000); end
    tick(1);
    checks++; if (st !== 8'b10_0_1_0_000) begin errors++; $display("FAIL rev_turn: got %b exp %b", st, 8'b10_0_1_0_000); end
    tick(7);
    checks++; if (st !== 8'b10_0_1_0_000) begin errors++; $display("FAIL rev_pre_f1: got %b exp %b", st, 8'b10_0_1_0_000); end
    tick(1);
    checks++; if (st !== 8'b01_0_0_1_001) begin errors++; $display("FAIL rev_f1_door: got %b exp %b", st, 8'b01_0_0_1_001); end
    andar_alvo = 2'd0;
    tick(4);
    checks++; if (st !== 8'b01_0_0_0_000) begin errors++; $display("FAIL rev_close: got %b exp %b", st, 8'b01_0_0_0_000); end
    andar_alvo = 2'd3;
    tick(1);
    checks++; if (st !== 8'b01_1_1_0_000) begin errors++; $display("FAIL notgt_start: got %b exp %b", st, 8'b01_1_1_0_000); end
    tick(3);
    andar_alvo = 2'd0;
    tick(5);
    checks++; if (st !== 8'b10_1_0_0_000) begin errors++; $display("FAIL notgt_stop: got %b exp %b", st, 8'b10_1_0_0_000); end
    tick(5);
    checks++; if (st !== 8'b10_1_0_0_000) begin errors++; $display("FAIL notgt_idle: got %b exp %b", st, 8'b10_1_0_0_000); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    andar_alvo = 2'd3;
    tick(11);
    checks++; if (st !== 8'b10_1_1_0_000) begin errors++; $display("FAIL midrst_moving: got %b exp %b", st, 8'b10_1_1_0_000); end
    rst = 1'b1;
    tick(1);
    checks++; if (st !== 8'b01_0_0_0_000) begin errors++; $display("FAIL midrst_travel: got %b exp %b", st, 8'b01_0_0_0_000); end
    rst = 1'b0;
    andar_alvo = 2'd1;
    tick(1);
    checks++; if (st !== 8'b01_0_0_1_001) begin errors++; $display("FAIL midrst_door_open: got %b exp %b", st, 8'b01_0_0_1_001); end
    andar_alvo = 2'd0;
    tick(1);
    rst = 1'b1;
    tick(1);
    checks++; if (st !== 8'b01_0_0_0_000) begin errors++; $display("FAIL midrst_door: got %b exp %b", st, 8'b01_0_0_0_000); end
    rst = 1'b0;
    tick(1);
    checks++; if (st !== 8'b01_0_0_0_000) begin errors++; $display("FAIL midrst_idle: got %b exp %b", st, 8'b01_0_0_0_000); end
  endtask

  task automatic test_door_extension();
    apply_reset();
    andar_alvo = 2'd1;
    tick(1);
    checks++; if (st !== 8'b01_0_0_1_001) begin errors++; $display("FAIL ext_open: got %b exp %b", st, 8'b01_0_0_1_001); end
    andar_alvo = 2'd0;
    tick(2);
    checks++; if (st !== 8'b01_0_0_1_000) begin errors++; $display("FAIL ext_mid: got %b exp %b", st, 8'b01_0_0_1_000); end
    andar_alvo = 2'd1;
    tick(1);
    checks++; if (st !== 8'b01_0_0_1_001) begin errors++; $display("FAIL ext_retrig1: got %b exp %b", st, 8'b01_0_0_1_001); end
    tick(1);
    checks++; if (st !== 8'b01_0_0_1_001) begin errors++; $display("FAIL ext_retrig2: got %b exp %b", st, 8'b01_0_0_1_001); end
    andar_alvo = 2'd0;
    tick(3);
    checks++; if (st !== 8'b01_0_0_1_000) begin errors++; $display("FAIL ext_hold: got %b exp %b", st, 8'b01_0_0_1_000); end
    tick(1);
    checks++; if (st !== 8'b01_0_0_0_000) begin errors++; $display("FAIL ext_close: got %b exp %b", st, 8'b01_0_0_0_000); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    chk_on = 1'b0;
    rst = 1'b1;
    andar_alvo = 2'd0;
    test_reset();
    test_full_climb();
    test_same_floor();
    test_intermediate_stop();
    test_reversal();
    test_mid_reset();
    test_door_extension();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
